// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition frame writer: sync byte defaults,
// emitter state encoding and frame overhead.
package acq_pkg;

    localparam logic [7:0] SYNC0_DEFAULT  = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT  = 8'h5A;
    // Sync x2, SEQ, LENH, LENL and CSUM wrap every frame's data bytes.
    localparam int         FRAME_OVERHEAD = 6;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        SEQ,
        LENH,
        LENL,
        DATA,
        CSUM
    } emit_state_t;

endpackage

// File: rtl/acq_frame_writer_if.sv
// Byte-write port towards eth_session: one strobe per byte, backpressured by full.
interface acq_frame_writer_if;

    logic [7:0] data;
    logic       wr;
    logic       full;

    modport master (output data, output wr, input full);
    modport slave  (input data, input wr, output full);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with a registered head output.
// dout always shows the oldest entry while empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;
    logic             head_from_din;

    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign push_ok       = push & ~full;
    assign pop_ok        = pop & ~empty;
    assign rd_ptr_nxt    = rd_ptr + AW'(pop_ok);
    // The pushed word becomes the head when nothing else remains after the pop.
    assign head_from_din = push_ok & (count == (AW+1)'(pop_ok));

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage and look-ahead head register; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
        dout <= head_from_din ? din : mem[rd_ptr_nxt];
    end

endmodule

// File: rtl/acq_frame_writer.sv
// Acquisition frame writer: on a trigger edge captures SAMPLES ADC bytes into a
// FIFO and emits  SYNC0 SYNC1 SEQ LENH LENL DATA[SAMPLES] CSUM  to eth_session.
module acq_frame_writer
    import acq_pkg::*;
#(
    parameter int         SAMPLES    = 1024,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC0      = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1      = SYNC1_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_trig,
    input  logic [7:0]                i_adc_data,
    input  logic                      i_adc_valid,
    acq_frame_writer_if.master        eth,
    output logic                      o_busy,
    output logic                      o_overrun,
    output logic [7:0]                o_frame_cnt
);

    localparam logic [15:0] LEN  = 16'(SAMPLES);
    localparam logic [15:0] LAST = 16'(SAMPLES - 1);

    emit_state_t state;
    logic        trig_q;
    logic        trig_edge;
    logic        cap_active;
    logic        cap_aborted;
    logic [15:0] cap_cnt;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [7:0]  seq_q;
    logic [7:0]  csum;
    logic [15:0] data_cnt;
    logic        data_ready;
    logic [7:0]  data_byte;

    assign trig_edge  = i_trig & ~trig_q & (state == IDLE);
    assign fifo_push  = cap_active & i_adc_valid & ~fifo_full;
    assign fifo_pop   = (state == DATA) & ~eth.full & ~fifo_empty;
    // Real samples always win; pads only fill in once capture has given up.
    assign data_ready = ~fifo_empty | cap_aborted;
    assign data_byte  = fifo_empty ? 8'hFF : fifo_dout;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (i_adc_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Trigger history; resets high so a level held through reset is not an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) trig_q <= 1'b1;
        else          trig_q <= i_trig;
    end

    // Capture control: count pushes, abort and flag overrun on a push into a full FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_active  <= 1'b0;
            cap_aborted <= 1'b0;
            cap_cnt     <= '0;
            o_overrun   <= 1'b0;
        end else if (trig_edge) begin
            cap_active  <= 1'b1;
            cap_aborted <= 1'b0;
            cap_cnt     <= '0;
            o_overrun   <= 1'b0;
        end else if (cap_active && i_adc_valid) begin
            if (fifo_full) begin
                o_overrun   <= 1'b1;
                cap_aborted <= 1'b1;
                cap_active  <= 1'b0;
            end else begin
                cap_cnt <= cap_cnt + 16'd1;
                if (cap_cnt == LAST) cap_active <= 1'b0;
            end
        end
    end

    // Emitter FSM: one registered byte per eligible cycle, advancing only on emit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            eth.data    <= 8'h00;
            eth.wr      <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_cnt <= 8'h00;
            seq_q       <= 8'h00;
            csum        <= 8'h00;
            data_cnt    <= '0;
        end else begin
            eth.wr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state    <= HDR0;
                        o_busy   <= 1'b1;
                        seq_q    <= o_frame_cnt;
                        csum     <= 8'h00;
                        data_cnt <= '0;
                    end
                end
                HDR0: if (!eth.full) begin
                    eth.wr   <= 1'b1;
                    eth.data <= SYNC0;
                    state    <= HDR1;
                end
                HDR1: if (!eth.full) begin
                    eth.wr   <= 1'b1;
                    eth.data <= SYNC1;
                    state    <= SEQ;
                end
                SEQ: if (!eth.full) begin
                    eth.wr   <= 1'b1;
                    eth.data <= seq_q;
                    csum     <= csum + seq_q;
                    state    <= LENH;
                end
                LENH: if (!eth.full) begin
                    eth.wr   <= 1'b1;
                    eth.data <= LEN[15:8];
                    csum     <= csum + LEN[15:8];
                    state    <= LENL;
                end
                LENL: if (!eth.full) begin
                    eth.wr   <= 1'b1;
                    eth.data <= LEN[7:0];
                    csum     <= csum + LEN[7:0];
                    state    <= DATA;
                end
                DATA: if (!eth.full && data_ready) begin
                    eth.wr   <= 1'b1;
                    eth.data <= data_byte;
                    csum     <= csum + data_byte;
                    data_cnt <= data_cnt + 16'd1;
                    if (data_cnt == LAST) state <= CSUM;
                end
                CSUM: if (!eth.full) begin
                    eth.wr      <= 1'b1;
                    eth.data    <= csum;
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                    o_busy      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
